alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised, handshaked sequential ALU core; next generation of the team's fixed-width combinational tt ALU.
- Adds a generic datapath width, valid/ready operand and result channels, and an iterative multi-cycle multiplier.
- Sits behind the tt_um top-level pin wrapper, which packs the dedicated/bidirectional pins into operands and results.

Parameters:
- W, 8, datapath width; power of two, 4..32.
- SHW, $clog2(W), shift-amount width (derived; do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  core can accept an operand beat.
- op  in  4  opcode.
- a  in  W  operand A.
- b  in  W  operand B; b[SHW-1:0] is the shift amount.
- use_acc  in  1  replace A with the accumulator (honoured only with ALU_ACC_EN).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  result, low half for MUL.
- result_hi  out  W  MUL high half; 0 for all other ops.
- carry, zero, overflow, err  out  1 each  flags.
- busy  out  1  state != IDLE.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (unsigned W×W -> 2W); 11-15 reserved.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch op/a/b. MUL goes to EXEC; every other op computes and goes to DONE.
  - EXEC: iterative shift-add, one bit per cycle, W cycles, then DONE.
  - DONE: out_valid=1. Outputs are registered and held stable until out_ready=1, then return to IDLE.
- in_ready is 0 outside IDLE; no overlap between operations.
- Latency, accept edge to out_valid: 1 cycle for single-cycle ops; W+1 cycles for MUL.
- Throughput: one op per 2 cycles when out_ready is tied high.
- Flags:
  - ADD: carry = carry-out of the W-bit sum.
  - SUB: carry = NOT borrow (a >= b unsigned).
  - overflow: signed overflow for ADD/SUB; 0 for all other ops.
  - Shifts: carry = last bit shifted out; shift amount 0 gives carry=0 and result=a.
  - SLT/SLTU: result = {0…,1} or 0.
  - MUL: carry = (result_hi != 0).
  - zero = (result==0 && result_hi==0).
- Reserved op: result=0, result_hi=0, carry=0, overflow=0, zero=1, err=1, latency 1. err=0 for all valid ops.
- Reset: all outputs 0, except in_ready=1 and zero=0. State returns to IDLE and the accumulator clears.
- Reset during EXEC or DONE aborts the operation; the pending result is discarded and never presented.
- in_valid arriving while not in IDLE is ignored. The producer must hold the beat until in_ready; there is no internal queue.

Optional Feature:
- ALU_ACC_EN defined:
  - Accumulator register, W bits, reset 0.
  - Loaded with result on every DONE→IDLE handshake, including reserved ops (loads 0).
  - When use_acc=1 at accept, the accumulator replaces a.
- ALU_ACC_EN undefined:
  - No accumulator register.
  - use_acc port is present but ignored.
  - Behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - op_e opcode enum (ADD..MUL, OP_RSVD_FIRST=11).
  - state_e {IDLE, EXEC, DONE}.
  - Flag-bit index constants.
- Sub-module alu_mul_iter:
  - Ports: start, a, b, done, prod[2W-1:0].
  - W-cycle shift-add; done pulses in the last cycle.
  - Reset by the same rst.
- Top FSM and single-cycle datapath live in alu_seq_core.

Test Plan (W=8):
- ADD a=0xF0 b=0x20 -> result=0x10, carry=1, overflow=0, zero=0; out_valid exactly 1 cycle after accept.
- SUB a=0x80 b=0x01 -> result=0x7F, carry=1, overflow=1. SRA a=0x81 b=1 -> result=0xC0, carry=1.
- MUL a=0xFF b=0xFF -> result_hi=0xFE, result=0x01, carry=1; out_valid 9 cycles after accept; busy high throughout.
- MUL accepted, out_ready held 0 for 5 cycles in DONE:
  - result stable throughout.
  - in_ready=0; a new in_valid in that window is not accepted.
  - Handshake completes on the first out_ready=1 cycle.
- rst=1 asserted 4 cycles into a MUL:
  - Next cycle: in_ready=1, out_valid=0, result=0, busy=0.
  - No stale result appears afterwards.
- op=0xC -> err=1, result=0, zero=1. With ALU_ACC_EN:
  - ADD a=5 b=0.
  - Then ADD use_acc=1 a=0x99 b=3 -> result=8.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for alu_seq_core: opcode and FSM state enums plus flag-vector bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD        = 4'd0,
        OP_SUB        = 4'd1,
        OP_AND        = 4'd2,
        OP_OR         = 4'd3,
        OP_XOR        = 4'd4,
        OP_SHL        = 4'd5,
        OP_SHR        = 4'd6,
        OP_SRA        = 4'd7,
        OP_SLT        = 4'd8,
        OP_SLTU       = 4'd9,
        OP_MUL        = 4'd10,
        OP_RSVD_FIRST = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_CARRY = 0;
    localparam int unsigned FLAG_ZERO  = 1;
    localparam int unsigned FLAG_OVF   = 2;
    localparam int unsigned FLAG_ERR   = 3;
    localparam int unsigned NUM_FLAGS  = 4;

endpackage

// File: rtl/alu_seq_core_if.sv
// Operand/result handshake bundle for alu_seq_core; slave is the core, master the producer/consumer.
interface alu_seq_core_if #(
    parameter int unsigned W = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         overflow;
    logic         err;
    logic         busy;

    modport slave (
        input  in_valid, op, a, b, use_acc, out_ready,
        output in_ready, out_valid, result, result_hi, carry, zero, overflow, err, busy
    );

    modport master (
        output in_valid, op, a, b, use_acc, out_ready,
        input  in_ready, out_valid, result, result_hi, carry, zero, overflow, err, busy
    );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned W x W shift-add multiplier; operands load on i_start, W steps follow.
// o_done and o_prod are combinational and valid together in the final step cycle.
module alu_mul_iter #(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [W-1:0]   i_a,
    input  logic [W-1:0]   i_b,
    output logic           o_done,
    output logic [2*W-1:0] o_prod
);
    localparam logic [SHW-1:0] CntLast = SHW'(W - 1);

    logic           r_run;
    logic [SHW-1:0] r_cnt;
    logic [W-1:0]   r_a;
    logic [2*W-1:0] r_prod;
    logic [W:0]     w_sum;
    logic [2*W-1:0] w_step;

    // Upper half accumulates partial sums; lower half holds the remaining multiplier bits.
    assign w_sum  = {1'b0, r_prod[2*W-1:W]} + (r_prod[0] ? {1'b0, r_a} : {(W+1){1'b0}});
    assign w_step = {w_sum, r_prod[W-1:1]};
    assign o_done = r_run && (r_cnt == CntLast);
    assign o_prod = w_step;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run  <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_prod <= '0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_cnt  <= '0;
            r_a    <= i_a;
            r_prod <= {{W{1'b0}}, i_b};
        end else if (r_run) begin
            r_prod <= w_step;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == CntLast) r_run <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: single-cycle ops finish in one cycle, MUL iterates for W cycles.
// Optional accumulator operand enabled by defining ALU_ACC_EN.
module alu_seq_core
    import alu_pkg::*;
#(
    parameter int unsigned W   = 8,
    parameter int unsigned SHW = $clog2(W)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    alu_seq_core_if.slave   bus
);
    state_e               r_state, w_state_nxt;
    logic [W-1:0]         r_result, r_result_hi;
    logic [NUM_FLAGS-1:0] r_flags;

    logic                 w_load;
    logic [W-1:0]         w_res_nxt, w_hi_nxt;
    logic [NUM_FLAGS-1:0] w_flags_nxt;

    logic [W-1:0]         w_a;
    logic [SHW-1:0]       w_sh;
    logic [W:0]           w_sum, w_diff, w_shl, w_shr, w_sra;
    logic [W-1:0]         w_alu_res;
    logic                 w_alu_c, w_alu_v, w_alu_e;

    logic                 w_mul_start, w_mul_done;
    logic [2*W-1:0]       w_mul_prod;

`ifdef ALU_ACC_EN
    logic [W-1:0] r_acc;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_acc <= '0;
        else if (r_state == DONE && bus.out_ready) r_acc <= r_result;
    end

    assign w_a = bus.use_acc ? r_acc : bus.a;
`else
    logic w_unused_use_acc;
    assign w_unused_use_acc = bus.use_acc;
    assign w_a = bus.a;
`endif

    assign w_sh   = bus.b[SHW-1:0];
    assign w_sum  = {1'b0, w_a} + {1'b0, bus.b};
    assign w_diff = {1'b0, w_a} - {1'b0, bus.b};
    // One guard bit beyond the operand catches the last bit shifted out (0 when shift is 0).
    assign w_shl  = {1'b0, w_a} << w_sh;
    assign w_shr  = {w_a, 1'b0} >> w_sh;
    assign w_sra  = $signed({w_a, 1'b0}) >>> w_sh;

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_e   = 1'b0;
        case (op_e'(bus.op))
            OP_ADD: begin
                w_alu_res = w_sum[W-1:0];
                w_alu_c   = w_sum[W];
                w_alu_v   = (w_a[W-1] == bus.b[W-1]) && (w_sum[W-1] != w_a[W-1]);
            end
            OP_SUB: begin
                w_alu_res = w_diff[W-1:0];
                w_alu_c   = ~w_diff[W];
                w_alu_v   = (w_a[W-1] != bus.b[W-1]) && (w_diff[W-1] != w_a[W-1]);
            end
            OP_AND:  w_alu_res = w_a & bus.b;
            OP_OR:   w_alu_res = w_a | bus.b;
            OP_XOR:  w_alu_res = w_a ^ bus.b;
            OP_SHL:  {w_alu_c, w_alu_res} = w_shl;
            OP_SHR:  {w_alu_res, w_alu_c} = w_shr;
            OP_SRA:  {w_alu_res, w_alu_c} = w_sra;
            OP_SLT:  w_alu_res = {{(W-1){1'b0}}, $signed(w_a) < $signed(bus.b)};
            OP_SLTU: w_alu_res = {{(W-1){1'b0}}, w_a < bus.b};
            OP_MUL:  w_alu_res = '0;
            default: w_alu_e   = 1'b1;
        endcase
    end

    assign w_mul_start = (r_state == IDLE) && bus.in_valid && (op_e'(bus.op) == OP_MUL);

    alu_mul_iter #(
        .W   (W),
        .SHW (SHW)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_mul_start),
        .i_a     (w_a),
        .i_b     (bus.b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_res_nxt   = '0;
        w_hi_nxt    = '0;
        w_flags_nxt = '0;
        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    if (w_mul_start) begin
                        w_state_nxt = EXEC;
                    end else begin
                        w_state_nxt           = DONE;
                        w_load                = 1'b1;
                        w_res_nxt             = w_alu_res;
                        w_flags_nxt[FLAG_CARRY] = w_alu_c;
                        w_flags_nxt[FLAG_OVF]   = w_alu_v;
                        w_flags_nxt[FLAG_ERR]   = w_alu_e;
                        w_flags_nxt[FLAG_ZERO]  = (w_alu_res == '0);
                    end
                end
            end
            EXEC: begin
                if (w_mul_done) begin
                    w_state_nxt             = DONE;
                    w_load                  = 1'b1;
                    w_res_nxt               = w_mul_prod[W-1:0];
                    w_hi_nxt                = w_mul_prod[2*W-1:W];
                    w_flags_nxt[FLAG_CARRY] = (w_mul_prod[2*W-1:W] != '0);
                    w_flags_nxt[FLAG_ZERO]  = (w_mul_prod == '0);
                end
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_result_hi <= '0;
            r_flags     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_result    <= w_res_nxt;
                r_result_hi <= w_hi_nxt;
                r_flags     <= w_flags_nxt;
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.result    = r_result;
    assign bus.result_hi = r_result_hi;
    assign bus.carry     = r_flags[FLAG_CARRY];
    assign bus.zero      = r_flags[FLAG_ZERO];
    assign bus.overflow  = r_flags[FLAG_OVF];
    assign bus.err       = r_flags[FLAG_ERR];
endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core at W=8: vector table plus stall/abort sequences.
module tb_alu_seq_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_seq_core_if #(.W(8)) bus ();

    alu_seq_core #(.W(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [7:0] hi;
        logic       c;
        logic       z;
        logic       v;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat and returns after out_valid is seen (or the cycle budget runs out).
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic ua, output int lat);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.use_acc  = ua;
        bus.in_valid = 1'b1;
        check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            check("busy_exec", {31'd0, bus.busy}, 32'd1);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_outs(input string name, input logic [7:0] res, input logic [7:0] hi,
                              input logic c, input logic z, input logic v, input logic e);
        check({name, ".result"},    {24'd0, bus.result},    {24'd0, res});
        check({name, ".result_hi"}, {24'd0, bus.result_hi}, {24'd0, hi});
        check({name, ".flags"},
              {28'd0, bus.carry, bus.zero, bus.overflow, bus.err},
              {28'd0, c, z, v, e});
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{"add",      4'd0,  8'hF0, 8'h20, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_ovf",  4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        vecs[2]  = '{"sra",      4'd7,  8'h81, 8'h01, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[3]  = '{"and",      4'd2,  8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[4]  = '{"or",       4'd3,  8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{"xor_zero", 4'd4,  8'hAA, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[6]  = '{"shl",      4'd5,  8'h81, 8'h01, 8'h02, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[7]  = '{"shr",      4'd6,  8'h81, 8'h04, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[8]  = '{"shl_zero", 4'd5,  8'h5A, 8'h00, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[9]  = '{"slt",      4'd8,  8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[10] = '{"sltu",     4'd9,  8'h80, 8'h01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        vecs[11] = '{"sub_brw",  4'd1,  8'h01, 8'h02, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vecs[12] = '{"add_ovf",  4'd0,  8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[13] = '{"mul_ff",   4'd10, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 9};
        vecs[14] = '{"mul_small",4'd10, 8'h0C, 8'h0D, 8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9};
        vecs[15] = '{"rsvd",     4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
        vecs[16] = '{"mul_zero", 4'd10, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 9};

        bus.in_valid  = 1'b0;
        bus.op        = 4'd0;
        bus.a         = 8'd0;
        bus.b         = 8'd0;
        bus.use_acc   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst.in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst.busy",      {31'd0, bus.busy},      32'd0);
        check_outs("rst", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, lat);
            check({vecs[i].name, ".latency"}, lat, vecs[i].lat);
            check({vecs[i].name, ".busy_done"}, {31'd0, bus.busy}, 32'd1);
            check_outs(vecs[i].name, vecs[i].res, vecs[i].hi, vecs[i].c, vecs[i].z,
                       vecs[i].v, vecs[i].e);
            retire();
            check({vecs[i].name, ".retired"}, {31'd0, bus.out_valid}, 32'd0);
        end

        // MUL result held in DONE while the consumer stalls; new beats must be refused.
        issue(4'd10, 8'h10, 8'h10, 1'b0, lat);
        check("stall.latency", lat, 9);
        for (int i = 0; i < 5; i++) begin
            check("stall.out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall.in_ready",  {31'd0, bus.in_ready},  32'd0);
            check_outs("stall", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
            bus.op       = 4'd0;
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            bus.in_valid = (i < 4);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("stall.still_valid", {31'd0, bus.out_valid}, 32'd1);
        retire();
        check("stall.hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("stall.hs_in_ready",  {31'd0, bus.in_ready},  32'd1);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.out_valid || bus.busy) seen++;
        end
        check("stall.no_accept", seen, 0);

        // Reset four cycles into a MUL discards it.
        bus.op       = 4'd10;
        bus.a        = 8'hFF;
        bus.b        = 8'hFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort.busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort.in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort.busy",      {31'd0, bus.busy},      32'd0);
        check("abort.result",    {24'd0, bus.result},    32'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort.no_stale", seen, 0);

        // Accumulator chaining; without the feature use_acc is ignored.
        issue(4'd0, 8'h05, 8'h00, 1'b0, lat);
        check_outs("acc_seed", 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        retire();
        issue(4'd0, 8'h99, 8'h03, 1'b1, lat);
`ifdef ALU_ACC_EN
        check_outs("acc_use", 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        check_outs("acc_use", 8'h9C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
        retire();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
